ram_rd_stream: RTL and testbench

- Single-clock read-side controller placed directly downstream of the asymmetric dual-port `ram`.
- Drives `ram.rd_addr` and captures `ram.rd_data` after a fixed read latency.
- Presents the data as a valid/ready stream through a 2-entry skid buffer.
- Returns a released read pointer upstream so the write side can compute full.
- Used when `ram` runs with `rd_clk` tied to the same clock as this block.

---
 rtl/ram_pkg.sv | 19 +
 rtl/skid_buf2.sv | 75 +++++++
 rtl/ram_rd_stream.sv | 88 ++++++++
 tb/tb_ram_rd_stream.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared defaults and pointer helpers for the RAM read-side stream controller.
package ram_pkg;

    localparam int unsigned DEF_RAM_ADDR_WIDTH = 6;
    localparam int unsigned DEF_RD_WIDTH       = 16;
    localparam int unsigned DEF_RD_IND         = 2;
    localparam int unsigned DEF_RD_LAT         = 1;
    localparam int unsigned DEF_PTR_W          = DEF_RAM_ADDR_WIDTH + 1;

    // Modulo-2**w distance from b forward to a.
    function automatic logic [31:0] ptr_dist(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready buffer; the head register drives the stream outputs.
module skid_buf2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [1:0]       cnt_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             pop_c;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        pop_c   = pop_i && valid_q;
        case ({push_i, pop_c})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = push_data_i;
                    cnt_d  = 2'd1;
                end else if (cnt_q == 2'd1) begin
                    tail_d = push_data_i;
                    cnt_d  = 2'd2;
                end
            end
            2'b01: begin
                // Head keeps its old value when draining to empty.
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                end
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end else begin
                    head_d = push_data_i;
                end
            end
            default: begin
            end
        endcase
        valid_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = head_q;
    assign valid_o = valid_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/ram_rd_stream.sv
// Read-side controller for the dual-port RAM: issues reads, tracks in-flight
// data and presents it as a valid/ready stream with a released read pointer.
module ram_rd_stream
    import ram_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
    parameter int unsigned RD_WIDTH       = DEF_RD_WIDTH,
    parameter int unsigned RD_IND         = DEF_RD_IND,
    parameter int unsigned RD_LAT         = DEF_RD_LAT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [RAM_ADDR_WIDTH:0]   wr_ptr,
    output logic [RAM_ADDR_WIDTH-1:0] rd_addr,
    input  logic [RD_WIDTH-1:0]       rd_data,
    output logic [RAM_ADDR_WIDTH:0]   rd_ptr,
    output logic [RD_WIDTH-1:0]       m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      ovf
);

    localparam int unsigned PTR_W     = RAM_ADDR_WIDTH + 1;
    localparam int unsigned RAM_DEPTH = 2 ** RAM_ADDR_WIDTH;

    logic [PTR_W-1:0]  iss_ptr_q, iss_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [RD_LAT-1:0] inflight_q, inflight_d;
    logic              ovf_q, ovf_d;

    logic [PTR_W-1:0]  avail_c;
    logic [PTR_W-1:0]  fill_c;
    logic [1:0]        inflight_cnt_c;
    logic [1:0]        buf_cnt;
    logic [2:0]        occ_c;
    logic              issue_c;
    logic              land_c;
    logic              pop_c;

    always_comb begin
        avail_c        = PTR_W'(ptr_dist(32'(wr_ptr), 32'(iss_ptr_q), PTR_W));
        fill_c         = PTR_W'(ptr_dist(32'(wr_ptr), 32'(rd_ptr_q), PTR_W));
        inflight_cnt_c = 2'($countones(inflight_q));
        pop_c          = m_valid && m_ready;
        land_c         = inflight_q[RD_LAT-1];
        // A word leaving this cycle frees its slot, keeping one word per clk.
        occ_c          = 3'(inflight_cnt_c) + 3'(buf_cnt) - 3'(pop_c);
        issue_c        = (avail_c >= PTR_W'(RD_IND)) && (occ_c < 3'd2);

        iss_ptr_d  = issue_c ? iss_ptr_q + PTR_W'(RD_IND) : iss_ptr_q;
        inflight_d = RD_LAT'({inflight_q, issue_c});
        rd_ptr_d   = land_c ? rd_ptr_q + PTR_W'(RD_IND) : rd_ptr_q;
        ovf_d      = ovf_q || (fill_c > PTR_W'(RAM_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            iss_ptr_q  <= iss_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            ovf_q      <= ovf_d;
        end
    end

    skid_buf2 #(
        .WIDTH(RD_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_i     (land_c),
        .push_data_i(rd_data),
        .pop_i      (pop_c),
        .data_o     (m_data),
        .valid_o    (m_valid),
        .cnt_o      (buf_cnt)
    );

    // The RAM samples the next read address straight from the issue pointer.
    assign rd_addr = iss_ptr_q[RAM_ADDR_WIDTH-1:0];
    assign rd_ptr  = rd_ptr_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_ram_rd_stream.sv
// Bench for ram_rd_stream: byte-cell RAM model, word-queue reference model,
// directed scenarios plus a randomized traffic phase.
module tb_ram_rd_stream;
    import ram_pkg::*;

    localparam int unsigned AW = DEF_RAM_ADDR_WIDTH;
    localparam int unsigned PW = DEF_PTR_W;
    localparam int unsigned DW = DEF_RD_WIDTH;

    logic          clk;
    logic          rst;
    logic [PW-1:0] wr_ptr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [PW-1:0] rd_ptr;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          ovf;

    logic [7:0]    mem [64];
    logic [15:0]   exp_q [$];
    logic [7:0]    pend;
    bit            pend_v;
    bit            cmp_en;
    bit            hold_q;
    logic [15:0]   hold_data;
    logic [15:0]   exp_w;
    int            n_checks;
    int            n_errors;
    int            n_xfer;

    ram_rd_stream dut (
        .clk    (clk),
        .rst    (rst),
        .wr_ptr (wr_ptr),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_ptr (rd_ptr),
        .m_data (m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with one clock of read latency; a read word packs two byte cells.
    always @(posedge clk) begin
        rd_data <= {mem[rd_addr + 6'd1], mem[rd_addr]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Write one cell behind the write pointer and extend the expected word stream.
    task automatic push_cell(input logic [7:0] v);
        mem[wr_ptr[AW-1:0]] = v;
        wr_ptr = wr_ptr + PW'(1);
        if (pend_v) begin
            exp_q.push_back({v, pend});
            pend_v = 1'b0;
        end else begin
            pend   = v;
            pend_v = 1'b1;
        end
    endtask

    task automatic do_reset(input bit chk);
        rst = 1'b1;
        #2;
        if (chk) begin
            check("async_rst_rd_addr", 32'(rd_addr), 32'd0);
            check("async_rst_rd_ptr",  32'(rd_ptr),  32'd0);
            check("async_rst_m_valid", 32'(m_valid), 32'd0);
            check("async_rst_m_data",  32'(m_data),  32'd0);
            check("async_rst_ovf",     32'(ovf),     32'd0);
        end
        exp_q.delete();
        pend_v = 1'b0;
        n_xfer = 0;
        wr_ptr = '0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic drain(input string name, input int budget);
        int c;
        c = 0;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || m_valid) && c < budget) begin
            step(1);
            c++;
        end
        check({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_m_valid"},    32'(m_valid),      32'd0);
    endtask

    // Scoreboard: every transfer against the model, held words stay put, no ovf.
    always @(negedge clk) begin
        if (rst || !cmp_en) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data",  32'(m_data),  32'(hold_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL stream_spurious: got 0x%0h, expected no word", m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("stream_data", 32'(m_data), 32'(exp_w));
                    n_xfer++;
                end
            end
            hold_q    = m_valid && !m_ready;
            hold_data = m_data;
            check("ovf_clear", 32'(ovf), 32'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] fill_m;
        int            n;
        int            room;

        n_checks = 0;
        n_errors = 0;
        n_xfer   = 0;
        cmp_en   = 1'b0;
        pend_v   = 1'b0;
        hold_q   = 1'b0;
        rst      = 1'b1;
        wr_ptr   = '0;
        m_ready  = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;

        // Reset values, then idle with an empty RAM.
        step(3);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_rd_ptr",  32'(rd_ptr),  32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data",  32'(m_data),  32'd0);
        check("rst_ovf",     32'(ovf),     32'd0);
        rst = 1'b0;
        step(5);
        check("idle_m_valid", 32'(m_valid), 32'd0);
        check("idle_rd_addr", 32'(rd_addr), 32'd0);
        check("idle_rd_ptr",  32'(rd_ptr),  32'd0);
        cmp_en = 1'b1;

        // Basic stream: cells 0..7 hold 0..7, consumer always ready.
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_cell(8'(i));
        check("basic_lat0_valid", 32'(m_valid), 32'd0);
        step(1);
        check("basic_lat1_valid", 32'(m_valid), 32'd0);
        step(1);
        check("basic_w0_valid", 32'(m_valid), 32'd1);
        check("basic_w0_data",  32'(m_data),  32'h0100);
        step(1);
        check("basic_w1_data",  32'(m_data),  32'h0302);
        step(1);
        check("basic_w2_data",  32'(m_data),  32'h0504);
        step(1);
        check("basic_w3_valid", 32'(m_valid), 32'd1);
        check("basic_w3_data",  32'(m_data),  32'h0706);
        step(1);
        check("basic_end_valid", 32'(m_valid), 32'd0);
        check("basic_end_rd_ptr", 32'(rd_ptr), 32'd8);
        check("basic_end_data_held", 32'(m_data), 32'h0706);

        // Backpressure: only two reads may be outstanding.
        do_reset(1'b0);
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_cell(8'(i));
        step(6);
        check("bp_rd_addr", 32'(rd_addr), 32'd4);
        check("bp_rd_ptr",  32'(rd_ptr),  32'd4);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        check("bp_m_data",  32'(m_data),  32'h0100);
        drain("bp", 50);
        check("bp_end_rd_ptr", 32'(rd_ptr), 32'd8);

        // Wrap: advance to cell 60, then cross the top of the RAM.
        do_reset(1'b0);
        m_ready = 1'b1;
        for (int i = 0; i < 60; i++) push_cell(8'($urandom));
        drain("wrap_pre", 200);
        check("wrap_start_rd_addr", 32'(rd_addr), 32'd60);
        for (int i = 0; i < 8; i++) push_cell(8'($urandom));
        step(1);
        check("wrap_rd_addr_62", 32'(rd_addr), 32'd62);
        step(1);
        check("wrap_rd_addr_0",  32'(rd_addr), 32'd0);
        step(1);
        check("wrap_rd_addr_2",  32'(rd_addr), 32'd2);
        drain("wrap", 50);
        check("wrap_rd_ptr",     32'(rd_ptr),    32'd68);
        check("wrap_rd_ptr_msb", 32'(rd_ptr[6]), 32'd1);

        // Partial word: a lone cell must not be read.
        do_reset(1'b0);
        m_ready = 1'b1;
        push_cell(8'hA5);
        step(4);
        check("partial_m_valid", 32'(m_valid), 32'd0);
        check("partial_rd_addr", 32'(rd_addr), 32'd0);
        push_cell(8'h5A);
        step(1);
        check("partial_lat1_valid", 32'(m_valid), 32'd0);
        step(1);
        check("partial_word_valid", 32'(m_valid), 32'd1);
        check("partial_word_data",  32'(m_data),  32'h5AA5);
        step(1);
        check("partial_end_valid",  32'(m_valid), 32'd0);
        check("partial_end_rd_ptr", 32'(rd_ptr),  32'd2);

        // Random traffic within the RAM capacity, with random backpressure.
        do_reset(1'b0);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if (cyc >= 600 && cyc < 680) m_ready = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                n      = int'($urandom_range(1, 5));
                fill_m = wr_ptr - PW'(2 * n_xfer);
                room   = 64 - int'(fill_m);
                if (n <= room) begin
                    for (int k = 0; k < n; k++) push_cell(8'($urandom));
                end
            end
            step(1);
        end
        drain("rand", 200);
        if (pend_v) push_cell(8'($urandom));
        drain("rand_pad", 50);
        check("rand_rd_ptr", 32'(rd_ptr), 32'(wr_ptr));

        // Overflow: write side runs more than a RAM depth ahead.
        do_reset(1'b0);
        cmp_en  = 1'b0;
        m_ready = 1'b1;
        wr_ptr  = PW'(65);
        check("ovf_not_yet", 32'(ovf), 32'd0);
        step(1);
        check("ovf_set", 32'(ovf), 32'd1);
        wr_ptr = PW'(20);
        step(4);
        check("ovf_sticky", 32'(ovf), 32'd1);
        #3;
        do_reset(1'b1);
        cmp_en = 1'b1;
        step(3);
        check("post_rst_ovf",     32'(ovf),     32'd0);
        check("post_rst_m_valid", 32'(m_valid), 32'd0);
        check("post_rst_rd_ptr",  32'(rd_ptr),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
